// File: rtl/replay_recorder.sv
// replay_recorder: instant-replay engine for the pong datapath.
// Stores one snapshot of NUM_OBJ rectangles per frame into a circular block RAM.
// On request it plays the stored frames back oldest-first, with an optional
// slow-motion hold and optional looping.
//
// Output protocol (the sink has no backpressure, so there is no ready):
//   play_valid is high while play_data carries a replayed frame. play_data
//   changes one cycle after the read pointer moves, and it holds its last value
//   whenever play_valid is low. play_done pulses for one cycle, together with
//   play_valid falling, only when a non-looping playback reaches its natural end.
module replay_recorder #(
    parameter int NUM_OBJ = 3,
    parameter int COORD_W = 12,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 9
) (
    input  logic                           CLK,
    input  logic                           RST_BTN,
    input  logic                           frame_tick,
    input  logic                           rec_en,
    input  logic                           play_req,
    input  logic                           play_stop,
    input  logic                           loop_en,
    input  logic [1:0]                     slow_sel,
    input  logic [NUM_OBJ*4*COORD_W-1:0]   rec_data,
    output logic [NUM_OBJ*4*COORD_W-1:0]   play_data,
    output logic                           play_valid,
    output logic                           play_done,
    output logic [1:0]                     state,
    output logic [ADDR_W:0]                frames_stored
);

    localparam int DATA_W = NUM_OBJ * 4 * COORD_W;
    localparam logic [ADDR_W:0]   FULL_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RECORD = 2'b01,
        ST_PLAY   = 2'b10
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]   start_ptr;
    logic [ADDR_W:0]     remaining;
    logic [2:0]          rep;
    logic [1:0]          slow_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_q;

    logic                wr_en;
    logic                accept;
    logic                frame_end;
    logic [2:0]          hold_m1;
    logic [ADDR_W-1:0]   wr_eff;
    logic [ADDR_W:0]     fs_eff;
    logic [ADDR_W-1:0]   start_eff;
    logic [ADDR_W-1:0]   rd_addr;

    assign state = state_q;

    // Next-pointer and acceptance decode; the recording side is evaluated "after"
    // a coincident write so a frame arriving with play_req is part of the replay.
    always_comb begin
        wr_en     = (state_q == ST_RECORD) && frame_tick;
        wr_eff    = wr_en ? (wr_ptr + PTR_ONE) : wr_ptr;
        fs_eff    = (wr_en && (frames_stored != FULL_C)) ? (frames_stored + ONE_C) : frames_stored;
        start_eff = (fs_eff == FULL_C) ? wr_eff : '0;
        accept    = play_req && !play_stop && (frames_stored != '0) && (state_q != ST_PLAY);
        case (slow_q)
            2'd0:    hold_m1 = 3'd0;
            2'd1:    hold_m1 = 3'd1;
            2'd2:    hold_m1 = 3'd3;
            default: hold_m1 = 3'd7;
        endcase
        frame_end = (state_q == ST_PLAY) && !play_stop && frame_tick && (rep == hold_m1);
        rd_addr   = rd_ptr;
        if (accept)
            rd_addr = start_eff;
        else if (frame_end && (remaining > ONE_C))
            rd_addr = rd_ptr + PTR_ONE;
        else if (frame_end && loop_en)
            rd_addr = start_ptr;
    end

    // Frame buffer: one write port, registered read of the next read pointer.
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= rec_data;
        rd_q <= mem[rd_addr];
    end

    // Control FSM with registered outputs.
    always_ff @(posedge CLK or posedge RST_BTN) begin
        if (RST_BTN) begin
            state_q       <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            start_ptr     <= '0;
            remaining     <= '0;
            rep           <= '0;
            slow_q        <= '0;
            frames_stored <= '0;
            play_data     <= '0;
            play_valid    <= 1'b0;
            play_done     <= 1'b0;
        end else begin
            play_done     <= 1'b0;
            rd_ptr        <= rd_addr;
            wr_ptr        <= wr_eff;
            frames_stored <= fs_eff;
            if (state_q == ST_PLAY)
                play_data <= rd_q;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q   <= ST_PLAY;
                        start_ptr <= start_eff;
                        remaining <= fs_eff;
                        rep       <= '0;
                        slow_q    <= slow_sel;
                    end else if (rec_en && !play_req) begin
                        // A fresh recording discards the previous one.
                        state_q       <= ST_RECORD;
                        wr_ptr        <= '0;
                        frames_stored <= '0;
                    end
                end
                ST_RECORD: begin
                    if (accept) begin
                        state_q   <= ST_PLAY;
                        start_ptr <= start_eff;
                        remaining <= fs_eff;
                        rep       <= '0;
                        slow_q    <= slow_sel;
                    end else if (!rec_en) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (play_stop) begin
                        state_q    <= ST_IDLE;
                        play_valid <= 1'b0;
                    end else begin
                        play_valid <= 1'b1;
                        if (frame_tick) begin
                            if (rep != hold_m1) begin
                                rep <= rep + 3'd1;
                            end else begin
                                rep <= '0;
                                if (remaining > ONE_C) begin
                                    remaining <= remaining - ONE_C;
                                end else if (loop_en) begin
                                    remaining <= frames_stored;
                                end else begin
                                    state_q    <= ST_IDLE;
                                    play_valid <= 1'b0;
                                    play_done  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_replay_recorder.sv
// tb_replay_recorder: directed bench for replay_recorder with a small buffer
// (DEPTH=8) so that wrap-around is reachable in a few frames.
module tb_replay_recorder;

    localparam int NUM_OBJ = 3;
    localparam int COORD_W = 12;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int DW      = NUM_OBJ * 4 * COORD_W;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST_BTN = 1'b1;
    always #5 CLK = ~CLK;

    logic            frame_tick = 1'b0;
    logic            rec_en     = 1'b0;
    logic            play_req   = 1'b0;
    logic            play_stop  = 1'b0;
    logic            loop_en    = 1'b0;
    logic [1:0]      slow_sel   = 2'd0;
    logic [DW-1:0]   rec_data   = '0;
    logic [DW-1:0]   play_data;
    logic            play_valid;
    logic            play_done;
    logic [1:0]      state;
    logic [ADDR_W:0] frames_stored;

    replay_recorder #(
        .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .CLK(CLK), .RST_BTN(RST_BTN), .frame_tick(frame_tick), .rec_en(rec_en),
        .play_req(play_req), .play_stop(play_stop), .loop_en(loop_en),
        .slow_sel(slow_sel), .rec_data(rec_data), .play_data(play_data),
        .play_valid(play_valid), .play_done(play_done), .state(state),
        .frames_stored(frames_stored)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    // Snapshot whose every coordinate is distinct: coord k of frame v = v*16+k.
    function automatic logic [DW-1:0] mk(input int v);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_OBJ*4; k++)
            r[k*COORD_W +: COORD_W] = COORD_W'(v*16 + k);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic rec_frames(input int base, input int n, input int exp_fs);
        rec_en = 1'b1;
        cyc();
        chk("rec enter state", int'(state), 1);
        chk("rec enter fs", int'(frames_stored), 0);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            rec_data   = mk(base + i);
            cyc();
            frame_tick = 1'b0;
        end
        chk("rec fs", int'(frames_stored), exp_fs);
        rec_en = 1'b0;
        cyc();
        chk("rec exit state", int'(state), 0);
    endtask

    task automatic start_play();
        play_req = 1'b1;
        cyc();
        play_req = 1'b0;
        chk("start state", int'(state), 2);
        chk("start valid", int'(play_valid), 0);
    endtask

    // Entered one cycle after play_req was accepted (state already PLAY).
    task automatic play_seq(input int first, input int n, input int hold, input int shows,
                            input bit end_done, input int exp_fs);
        logic [DW-1:0] cur;
        bit last;
        exp_q.delete();
        for (int j = 0; j <= shows; j++)
            exp_q.push_back(mk(first + (j % n)));
        cyc();
        cur = exp_q.pop_front();
        chk("play first valid", int'(play_valid), 1);
        chk_d("play first data", play_data, cur);
        for (int j = 0; j < shows; j++) begin
            for (int r = 0; r < hold; r++) begin
                frame_tick = 1'b1;
                cyc();
                frame_tick = 1'b0;
                last = end_done && (j == shows-1) && (r == hold-1);
                if (last) begin
                    chk("play end done", int'(play_done), 1);
                    chk("play end valid", int'(play_valid), 0);
                    chk("play end state", int'(state), 0);
                end else begin
                    chk("play tick done", int'(play_done), 0);
                    chk("play tick valid", int'(play_valid), 1);
                    chk("play tick state", int'(state), 2);
                end
                chk("play fs frozen", int'(frames_stored), exp_fs);
                if ((r == hold-1) && !last)
                    cur = exp_q.pop_front();
                cyc();
                chk_d($sformatf("play data f%0d r%0d", j, r), play_data, cur);
                chk("play done low", int'(play_done), 0);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic tick;
        logic rec;
        logic req;
        int   din;
        int   e_state;
        int   e_valid;
        int   e_done;
        int   e_fs;
        int   e_data;   // -1: all-zero snapshot
    } vec_t;

    vec_t tbl[21];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // tick rec req din | state valid done fs data
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 1, 0, 0, 0, -1};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 0, 1, 0, 0, 1, -1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 0, 1, 0, 0, 1, -1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1, 1, 0, 0, 2, -1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2, 1, 0, 0, 3, -1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3, 1, 0, 0, 4, -1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 4, 1, 0, 0, 5, -1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 5, -1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 0, 2, 0, 0, 5, -1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 0, 2, 1, 0, 5, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 0, 2, 1, 0, 5, 0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 0, 2, 1, 0, 5, 0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 0, 2, 1, 0, 5, 1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 0, 2, 1, 0, 5, 1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 0, 2, 1, 0, 5, 2};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 0, 2, 1, 0, 5, 2};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 0, 2, 1, 0, 5, 3};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 0, 2, 1, 0, 5, 3};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 0, 2, 1, 0, 5, 4};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 5, 4};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 5, 4};

        // Reset state
        cyc();
        cyc();
        RST_BTN = 1'b0;
        cyc();
        chk("reset state", int'(state), 0);
        chk("reset fs", int'(frames_stored), 0);
        chk("reset valid", int'(play_valid), 0);
        chk("reset done", int'(play_done), 0);
        chk_d("reset data", play_data, '0);

        // play_req with nothing stored is ignored
        play_req = 1'b1;
        cyc();
        play_req = 1'b0;
        chk("empty req state", int'(state), 0);
        cyc();
        chk("empty req valid", int'(play_valid), 0);

        // Basic record of 5 frames and full-speed playback
        for (int i = 0; i < 21; i++) begin
            frame_tick = tbl[i].tick;
            rec_en     = tbl[i].rec;
            play_req   = tbl[i].req;
            rec_data   = mk(tbl[i].din);
            cyc();
            frame_tick = 1'b0;
            play_req   = 1'b0;
            chk($sformatf("t1[%0d] state", i), int'(state), tbl[i].e_state);
            chk($sformatf("t1[%0d] valid", i), int'(play_valid), tbl[i].e_valid);
            chk($sformatf("t1[%0d] done", i), int'(play_done), tbl[i].e_done);
            chk($sformatf("t1[%0d] fs", i), int'(frames_stored), tbl[i].e_fs);
            chk_d($sformatf("t1[%0d] data", i), play_data,
                  (tbl[i].e_data < 0) ? '0 : mk(tbl[i].e_data));
        end

        // Wrap: 11 frames into 8 slots, replay starts at the oldest (frame 3)
        rec_frames(0, 11, 8);
        slow_sel = 2'd0;
        start_play();
        play_seq(3, 8, 1, 8, 1'b1, 8);

        // Slow motion x4, slow_sel change after acceptance must not matter
        rec_frames(20, 3, 3);
        slow_sel = 2'd2;
        start_play();
        slow_sel = 2'd0;
        play_seq(20, 3, 4, 3, 1'b1, 3);

        // Looping playback, then abort with play_stop
        rec_frames(50, 3, 3);
        loop_en = 1'b1;
        start_play();
        play_seq(50, 3, 1, 6, 1'b0, 3);
        play_stop = 1'b1;
        cyc();
        play_stop = 1'b0;
        chk("stop state", int'(state), 0);
        chk("stop valid", int'(play_valid), 0);
        chk("stop done", int'(play_done), 0);
        cyc();
        chk("stop done after", int'(play_done), 0);
        chk_d("stop data hold", play_data, mk(50));
        loop_en = 1'b0;

        // play_stop beats play_req in RECORD; play_req with a coincident tick
        rec_en = 1'b1;
        cyc();
        chk("t5 enter", int'(state), 1);
        for (int i = 0; i < 2; i++) begin
            frame_tick = 1'b1;
            rec_data   = mk(30 + i);
            cyc();
            frame_tick = 1'b0;
        end
        play_req  = 1'b1;
        play_stop = 1'b1;
        cyc();
        play_req  = 1'b0;
        play_stop = 1'b0;
        chk("req+stop state", int'(state), 1);
        chk("req+stop valid", int'(play_valid), 0);
        play_req   = 1'b1;
        frame_tick = 1'b1;
        rec_data   = mk(32);
        cyc();
        play_req   = 1'b0;
        frame_tick = 1'b0;
        rec_data   = mk(99);
        chk("req+tick state", int'(state), 2);
        chk("req+tick fs", int'(frames_stored), 3);
        play_seq(30, 3, 1, 3, 1'b1, 3);
        chk("re-record state", int'(state), 1);
        chk("re-record fs", int'(frames_stored), 0);
        rec_en = 1'b0;
        cyc();
        chk("t5 idle", int'(state), 0);

        // Asynchronous reset in the middle of PLAY
        rec_frames(40, 3, 3);
        start_play();
        cyc();
        chk("pre-reset valid", int'(play_valid), 1);
        #2;
        RST_BTN = 1'b1;
        #1;
        chk("async rst state", int'(state), 0);
        chk("async rst valid", int'(play_valid), 0);
        chk("async rst fs", int'(frames_stored), 0);
        chk_d("async rst data", play_data, '0);
        cyc();
        cyc();
        RST_BTN = 1'b0;
        play_req = 1'b1;
        cyc();
        play_req = 1'b0;
        chk("post-rst req state", int'(state), 0);
        cyc();
        chk("post-rst valid", int'(play_valid), 0);
        chk("post-rst state", int'(state), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
